// File: rtl/s2_result_collector.sv
// rtl/s2_result_collector.sv - stage-2 window sequencer, result frame buffer and stage-3 streamer
//
// Walks every (filter, row, col) window position, captures each datapath
// result into a frame buffer, then streams the frame out address-tagged.
//
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   start                     begin one frame (taken only when idle)
//   proc_dir/row/col/idx      registered window selects to the datapath
//   proc_res                  signed datapath result, PROC_LAT cycles after the selects
//   busy, done                frame in progress / one-cycle completion pulse
//   out_valid/ready/data/addr/last  stage-3 stream
module s2_result_collector #(
  parameter int N_FILT   = 4,
  parameter int OUT_DIM  = 6,
  parameter int IN_W     = 35,
  parameter int OUT_W    = 35,
  parameter int PROC_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [1:0]       proc_dir,
  output logic [2:0]       proc_row,
  output logic [2:0]       proc_col,
  output logic [5:0]       proc_idx,
  input  logic [IN_W-1:0]  proc_res,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [7:0]       out_addr,
  output logic             out_last
);
  localparam int WIN   = OUT_DIM * OUT_DIM;
  localparam int DEPTH = N_FILT * WIN;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_STREAM, S_DONE} state_t;

  state_t           state;
  logic [7:0]       scan_cnt;
  logic [7:0]       rd_ptr;
  logic             issue_valid;
  logic [7:0]       issue_addr;
  logic             cap_valid;
  logic [7:0]       cap_addr;
  logic [OUT_W-1:0] cap_data;
  logic [OUT_W-1:0] mem [DEPTH];

  // scan_cnt keeps running past the last issue so the pipeline can drain.
  assign issue_valid = (state == S_SCAN) && (scan_cnt < 8'(DEPTH));
  assign issue_addr  = 8'(proc_dir) * 8'(WIN) + 8'(proc_idx);

  // Issue tag follows the datapath latency so each result lands at its own address.
  generate
    if (PROC_LAT == 0) begin : g_lat0
      assign cap_valid = issue_valid;
      assign cap_addr  = issue_addr;
    end else begin : g_latn
      logic [PROC_LAT-1:0] vld_sr;
      logic [7:0]          addr_sr [PROC_LAT];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_sr <= '0;
          for (int i = 0; i < PROC_LAT; i++) addr_sr[i] <= '0;
        end else begin
          vld_sr[0]  <= issue_valid;
          addr_sr[0] <= issue_addr;
          for (int i = 1; i < PROC_LAT; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            addr_sr[i] <= addr_sr[i-1];
          end
        end
      end
      assign cap_valid = vld_sr[PROC_LAT-1];
      assign cap_addr  = addr_sr[PROC_LAT-1];
    end
  endgenerate

  // Narrowing to the stream width saturates instead of wrapping.
  generate
    if (OUT_W >= IN_W) begin : g_ext
      assign cap_data = OUT_W'($signed(proc_res));
    end else begin : g_sat
      localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        cap_data = proc_res[OUT_W-1:0];
        if ($signed(proc_res) > MAX_V)      cap_data = {1'b0, {(OUT_W-1){1'b1}}};
        else if ($signed(proc_res) < MIN_V) cap_data = {1'b1, {(OUT_W-1){1'b0}}};
      end
    end
  endgenerate

  // Buffer contents need no reset; every entry is rewritten before it is streamed.
  always_ff @(posedge clk) begin
    if (cap_valid) mem[cap_addr] <= cap_data;
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign out_addr = out_valid ? rd_ptr : '0;
  assign out_last = out_valid && (rd_ptr == 8'(DEPTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      scan_cnt  <= '0;
      rd_ptr    <= '0;
      proc_dir  <= '0;
      proc_row  <= '0;
      proc_col  <= '0;
      proc_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SCAN;
            busy     <= 1'b1;
            scan_cnt <= '0;
            proc_dir <= '0;
            proc_row <= '0;
            proc_col <= '0;
            proc_idx <= '0;
          end
        end
        S_SCAN: begin
          scan_cnt <= scan_cnt + 8'd1;
          // Selects stop at the final window and hold there through the drain.
          if (scan_cnt < 8'(DEPTH-1)) begin
            if (proc_col == 3'(OUT_DIM-1)) begin
              proc_col <= '0;
              if (proc_row == 3'(OUT_DIM-1)) begin
                proc_row <= '0;
                proc_idx <= '0;
                proc_dir <= proc_dir + 2'd1;
              end else begin
                proc_row <= proc_row + 3'd1;
                proc_idx <= proc_idx + 6'd1;
              end
            end else begin
              proc_col <= proc_col + 3'd1;
              proc_idx <= proc_idx + 6'd1;
            end
          end
          if (scan_cnt == 8'(DEPTH-1+PROC_LAT)) begin
            state     <= S_STREAM;
            rd_ptr    <= '0;
            out_valid <= 1'b1;
          end
        end
        S_STREAM: begin
          if (out_valid && out_ready) begin
            if (rd_ptr == 8'(DEPTH-1)) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              rd_ptr <= rd_ptr + 8'd1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
